// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler with a 2-entry valid/ready output buffer.
// Drops a completed word when the buffer is full and no pop occurs, and latches a sticky overflow flag.
module serial_word_deserializer #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter string       BIT_ORDER  = "MSB_FIRST"
) (
  input  logic                                 clk,
  input  logic                                 aclr,
  input  logic                                 sclr,
  input  logic                                 bit_in,
  input  logic                                 bit_en,
  input  logic                                 frame_start,
  output logic [WORD_WIDTH-1:0]                word_out,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [$clog2(WORD_WIDTH+1)-1:0]      bit_count,
  output logic                                 busy,
  output logic                                 overflow
);

  localparam int unsigned W   = WORD_WIDTH;
  localparam int unsigned CW  = $clog2(WORD_WIDTH + 1);
  localparam bit          MSB = (BIT_ORDER == "MSB_FIRST");

  logic [W-1:0]  asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  slot0_q, slot0_d;
  logic [W-1:0]  slot1_q, slot1_d;
  logic [1:0]    fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  shifted;
  logic [W-1:0]  fresh;
  logic          push;
  logic          pop;

  // Next-state: assembly, buffer and sticky flag; sclr overrides everything
  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = (fill_q != 2'd0) && word_ready;
    shifted = MSB ? {asm_q[W-2:0], bit_in} : {bit_in, asm_q[W-1:1]};
    fresh   = MSB ? {{(W-1){1'b0}}, bit_in} : {bit_in, {(W-1){1'b0}}};

    if (frame_start) begin
      asm_d = bit_en ? fresh : '0;
      cnt_d = bit_en ? CW'(1) : '0;
    end else if (bit_en) begin
      if (cnt_q == CW'(W - 1)) begin
        push  = 1'b1;
        asm_d = '0;
        cnt_d = '0;
      end else begin
        asm_d = shifted;
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Head always lives in slot0; unused slots are kept at zero
    if (push && pop) begin
      if (fill_q == 2'd1) begin
        slot0_d = shifted;
      end else begin
        slot0_d = slot1_q;
        slot1_d = shifted;
      end
    end else if (pop) begin
      slot0_d = slot1_q;
      slot1_d = '0;
      fill_d  = fill_q - 2'd1;
    end else if (push) begin
      if (fill_q == 2'd0) begin
        slot0_d = shifted;
        fill_d  = 2'd1;
      end else if (fill_q == 2'd1) begin
        slot1_d = shifted;
        fill_d  = 2'd2;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (sclr) begin
      asm_d   = '0;
      cnt_d   = '0;
      slot0_d = '0;
      slot1_d = '0;
      fill_d  = '0;
      ovf_d   = 1'b0;
    end

    valid_d = (fill_d != 2'd0);
    busy_d  = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign word_out   = slot0_q;
  assign word_valid = valid_q;
  assign bit_count  = cnt_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench: one MSB_FIRST and one LSB_FIRST instance share the same serial stream.
module tb_serial_word_deserializer;

  logic       clk = 1'b0;
  logic       aclr, sclr, bit_in, bit_en, frame_start, word_ready;
  logic [7:0] wo_m, wo_l;
  logic       wv_m, wv_l, busy_m, busy_l, ovf_m, ovf_l;
  logic [3:0] bc_m, bc_l;
  int         n_vec = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WORD_WIDTH(8), .BIT_ORDER("MSB_FIRST")) dut_m (
    .clk(clk), .aclr(aclr), .sclr(sclr), .bit_in(bit_in), .bit_en(bit_en),
    .frame_start(frame_start), .word_out(wo_m), .word_valid(wv_m),
    .word_ready(word_ready), .bit_count(bc_m), .busy(busy_m), .overflow(ovf_m));

  serial_word_deserializer #(.WORD_WIDTH(8), .BIT_ORDER("LSB_FIRST")) dut_l (
    .clk(clk), .aclr(aclr), .sclr(sclr), .bit_in(bit_in), .bit_en(bit_en),
    .frame_start(frame_start), .word_out(wo_l), .word_valid(wv_l),
    .word_ready(word_ready), .bit_count(bc_l), .busy(busy_l), .overflow(ovf_l));

  // Inputs change and outputs are sampled 1 ns after each rising edge
  task automatic bit_step(input logic b, input logic en);
    bit_in = b;
    bit_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bit_step(w[i], 1'b1);
  endtask

  task automatic test_reset;
    aclr = 1'b1; sclr = 1'b0; bit_in = 1'b0; bit_en = 1'b0;
    frame_start = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (wo_m !== 8'h00) begin n_miss++; $display("FAIL reset_word: got %h want 00", wo_m); end
    n_vec++; if (wv_m !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", wv_m); end
    n_vec++; if (bc_m !== 4'd0 || busy_m !== 1'b0) begin n_miss++; $display("FAIL reset_count: got %0d/%b want 0/0", bc_m, busy_m); end
    n_vec++; if (ovf_m !== 1'b0) begin n_miss++; $display("FAIL reset_ovf: got %b want 0", ovf_m); end
    aclr = 1'b0;
  endtask

  task automatic test_msb_lsb;
    logic [7:0] s;
    s = 8'b1100_0001;
    word_ready = 1'b1;
    for (int i = 7; i >= 1; i--) bit_step(s[i], 1'b1);
    n_vec++; if (bc_m !== 4'd7 || busy_m !== 1'b1) begin n_miss++; $display("FAIL seven_bits_count: got %0d/%b want 7/1", bc_m, busy_m); end
    n_vec++; if (wv_m !== 1'b0) begin n_miss++; $display("FAIL early_valid: got %b want 0", wv_m); end
    bit_step(s[0], 1'b1);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'hC1) begin n_miss++; $display("FAIL msb_word: got %b/%h want 1/c1", wv_m, wo_m); end
    n_vec++; if (wv_l !== 1'b1 || wo_l !== 8'h83) begin n_miss++; $display("FAIL lsb_word: got %b/%h want 1/83", wv_l, wo_l); end
    n_vec++; if (bc_m !== 4'd0 || busy_m !== 1'b0) begin n_miss++; $display("FAIL wrap_count: got %0d/%b want 0/0", bc_m, busy_m); end
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b0 || wo_m !== 8'h00) begin n_miss++; $display("FAIL one_cycle_valid: got %b/%h want 0/00", wv_m, wo_m); end
  endtask

  task automatic test_gaps;
    logic [7:0] s;
    s = 8'b1100_0001;
    word_ready = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      bit_step(s[i], 1'b1);
      bit_step(1'b0, 1'b0);
    end
    n_vec++; if (wv_m !== 1'b0 || bc_m !== 4'd7) begin n_miss++; $display("FAIL gap_hold: got %b/%0d want 0/7", wv_m, bc_m); end
    bit_step(s[0], 1'b1);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'hC1) begin n_miss++; $display("FAIL gap_msb: got %b/%h want 1/c1", wv_m, wo_m); end
    n_vec++; if (wv_l !== 1'b1 || wo_l !== 8'h83) begin n_miss++; $display("FAIL gap_lsb: got %b/%h want 1/83", wv_l, wo_l); end
    bit_step(1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    word_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h11 || ovf_m !== 1'b0) begin n_miss++; $display("FAIL full_no_ovf: got %b/%h/%b want 1/11/0", wv_m, wo_m, ovf_m); end
    send_word(8'h33);
    n_vec++; if (ovf_m !== 1'b1 || wo_m !== 8'h11) begin n_miss++; $display("FAIL ovf_set: got %b/%h want 1/11", ovf_m, wo_m); end
    word_ready = 1'b1;
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h22) begin n_miss++; $display("FAIL ovf_second: got %b/%h want 1/22", wv_m, wo_m); end
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b0 || wo_m !== 8'h00) begin n_miss++; $display("FAIL ovf_drop: got %b/%h want 0/00", wv_m, wo_m); end
    n_vec++; if (ovf_m !== 1'b1) begin n_miss++; $display("FAIL ovf_sticky: got %b want 1", ovf_m); end
    sclr = 1'b1;
    bit_step(1'b0, 1'b0);
    sclr = 1'b0;
    n_vec++; if (ovf_m !== 1'b0) begin n_miss++; $display("FAIL sclr_ovf: got %b want 0", ovf_m); end
  endtask

  task automatic test_frame_start;
    word_ready = 1'b1;
    repeat (5) bit_step(1'b1, 1'b1);
    n_vec++; if (bc_m !== 4'd5) begin n_miss++; $display("FAIL partial_count: got %0d want 5", bc_m); end
    frame_start = 1'b1;
    bit_step(1'b0, 1'b0);
    frame_start = 1'b0;
    n_vec++; if (bc_m !== 4'd0 || busy_m !== 1'b0) begin n_miss++; $display("FAIL fs_clear: got %0d/%b want 0/0", bc_m, busy_m); end
    send_word(8'h5A);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h5A || bc_m !== 4'd0) begin n_miss++; $display("FAIL fs_word: got %b/%h/%0d want 1/5a/0", wv_m, wo_m, bc_m); end
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b0) begin n_miss++; $display("FAIL fs_single: got %b want 0", wv_m); end
    // frame_start on what would be the completing bit restarts instead
    repeat (7) bit_step(1'b0, 1'b1);
    frame_start = 1'b1;
    bit_step(1'b1, 1'b1);
    frame_start = 1'b0;
    n_vec++; if (wv_m !== 1'b0 || bc_m !== 4'd1) begin n_miss++; $display("FAIL fs_precedence: got %b/%0d want 0/1", wv_m, bc_m); end
    for (int i = 0; i < 7; i++) bit_step(i[0], 1'b1);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'hAA) begin n_miss++; $display("FAIL fs_restart_word: got %b/%h want 1/aa", wv_m, wo_m); end
    bit_step(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    s = 8'h03;
    word_ready = 1'b0;
    send_word(8'h01);
    send_word(8'h02);
    for (int i = 7; i >= 1; i--) bit_step(s[i], 1'b1);
    word_ready = 1'b1;
    bit_step(s[0], 1'b1);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h02 || ovf_m !== 1'b0) begin n_miss++; $display("FAIL b2b_first: got %b/%h/%b want 1/02/0", wv_m, wo_m, ovf_m); end
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h03) begin n_miss++; $display("FAIL b2b_second: got %b/%h want 1/03", wv_m, wo_m); end
    bit_step(1'b0, 1'b0);
    n_vec++; if (wv_m !== 1'b0 || ovf_m !== 1'b0) begin n_miss++; $display("FAIL b2b_drain: got %b/%b want 0/0", wv_m, ovf_m); end
  endtask

  task automatic test_aclr_sclr;
    word_ready = 1'b0;
    send_word(8'h77);
    bit_step(1'b1, 1'b1); bit_step(1'b0, 1'b1); bit_step(1'b1, 1'b1); bit_step(1'b0, 1'b1);
    n_vec++; if (wv_m !== 1'b1 || bc_m !== 4'd4) begin n_miss++; $display("FAIL pre_aclr: got %b/%0d want 1/4", wv_m, bc_m); end
    aclr = 1'b1;
    #2;
    n_vec++; if (wo_m !== 8'h00 || wv_m !== 1'b0 || bc_m !== 4'd0 || busy_m !== 1'b0 || ovf_m !== 1'b0) begin
      n_miss++; $display("FAIL aclr_async: got %h/%b/%0d/%b/%b want 00/0/0/0/0", wo_m, wv_m, bc_m, busy_m, ovf_m);
    end
    aclr = 1'b0;
    word_ready = 1'b1;
    send_word(8'hF0);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'hF0) begin n_miss++; $display("FAIL post_aclr_word: got %b/%h want 1/f0", wv_m, wo_m); end
    bit_step(1'b0, 1'b0);
    repeat (3) bit_step(1'b1, 1'b1);
    sclr = 1'b1;
    bit_step(1'b1, 1'b1);
    sclr = 1'b0;
    n_vec++; if (bc_m !== 4'd0 || busy_m !== 1'b0) begin n_miss++; $display("FAIL sclr_bit: got %0d/%b want 0/0", bc_m, busy_m); end
    send_word(8'h3C);
    n_vec++; if (wv_m !== 1'b1 || wo_m !== 8'h3C || bc_m !== 4'd0) begin n_miss++; $display("FAIL post_sclr_word: got %b/%h/%0d want 1/3c/0", wv_m, wo_m, bc_m); end
    bit_step(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_gaps();
    test_overflow();
    test_frame_start();
    test_back_to_back();
    test_aclr_sclr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
